store_queue: RTL and testbench

- Parametrised store unit for the MEM stage, generalising the byte-enable/AdES store path.
- Decodes store size and address into lane-aligned byte enables and write data, and raises AdES on misaligned, out-of-map or illegal-peripheral stores.
- Buffers legal stores in a DEPTH-entry FIFO and drains them to the data bus over a req/ack handshake.
- Flags pending-store address hazards so the load path can stall.

---
 rtl/store_pkg.sv | 42 ++++
 rtl/store_align.sv | 62 ++++++
 rtl/store_queue.sv | 141 ++++++++++++++
 tb/tb_store_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the MEM-stage store unit.
//   st_size_e     : store size encodings (byte/half/word/dword)
//   *_START/*_END : legal store address map (inclusive bounds)
//   TC_COUNT_OFS  : offset of the read-only count register inside a timer block
//   store_entry_t : one store-queue entry {addr, byteen, wdata}, sized for the
//                   widest legal configuration; narrower builds zero-extend
//   in_rgn        : inclusive address-range test
package store_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } st_size_e;

  localparam logic [31:0] DM_START    = 32'h0000_0000;
  localparam logic [31:0] DM_END      = 32'h0000_2FFF;
  localparam logic [31:0] TC0_START   = 32'h0000_7F00;
  localparam logic [31:0] TC0_END     = 32'h0000_7F0B;
  localparam logic [31:0] TC1_START   = 32'h0000_7F10;
  localparam logic [31:0] TC1_END     = 32'h0000_7F1B;
  localparam logic [31:0] STALL_START = 32'h0000_7F20;
  localparam logic [31:0] STALL_END   = 32'h0000_7F23;
  localparam logic [31:0] TC_COUNT_OFS = 32'd8;

  localparam int unsigned ENT_ADDR_W = 64;
  localparam int unsigned ENT_DATA_W = 64;
  localparam int unsigned ENT_NB     = 8;

  typedef struct packed {
    logic [ENT_ADDR_W-1:0] addr;
    logic [ENT_NB-1:0]     byteen;
    logic [ENT_DATA_W-1:0] wdata;
  } store_entry_t;

  function automatic logic in_rgn(input logic [63:0] a, input logic [31:0] lo,
                                  input logic [31:0] hi);
    return (a >= 64'(lo)) && (a <= 64'(hi));
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store decode: size/lane -> lane-aligned byte enables and data,
// word-aligned address, and the AdES (store address exception) checks.
//   st_valid/st_size/st_addr/st_wdata : store request from MEM stage
//   al_addr   : st_addr with the lane bits cleared
//   al_byteen : byte enables for the addressed lanes
//   al_wdata  : right-justified data shifted into its lanes, other bits zero
//   exc_ades  : misaligned, oversize, unmapped or illegal peripheral store
module store_align
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  st_valid,
  input  logic [1:0]            st_size,
  input  logic [ADDR_W-1:0]     st_addr,
  input  logic [DATA_W-1:0]     st_wdata,
  output logic [ADDR_W-1:0]     al_addr,
  output logic [DATA_W/8-1:0]   al_byteen,
  output logic [DATA_W-1:0]     al_wdata,
  output logic                  exc_ades
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int unsigned DW = DATA_W;

  logic [3:0]        nbytes;
  logic [2:0]        amask;
  logic [LB-1:0]     lane;
  logic [15:0]       lane_mask;
  int unsigned       nbits;
  logic [DATA_W-1:0] data_mask;
  logic [63:0]       a64;
  logic              in_tc, in_cnt, in_any;
  logic              err_align, err_size, err_range, err_periph;

  always_comb begin
    nbytes    = 4'd1 << st_size;
    amask     = 3'(nbytes - 4'd1);
    lane      = st_addr[LB-1:0];
    lane_mask = ((16'd1 << nbytes) - 16'd1) << lane;
    al_byteen = lane_mask[NB-1:0];
    nbits     = 32'(nbytes) << 3;
    data_mask = (nbits >= DW) ? '1 : ((DATA_W'(1) << nbits) - DATA_W'(1));
    al_wdata  = (st_wdata & data_mask) << {lane, 3'b000};
    al_addr   = st_addr & ~ADDR_W'(NB - 1);

    a64    = 64'(st_addr);
    in_tc  = in_rgn(a64, TC0_START, TC0_END) | in_rgn(a64, TC1_START, TC1_END);
    in_any = in_rgn(a64, DM_START, DM_END) | in_tc | in_rgn(a64, STALL_START, STALL_END);
    in_cnt = in_rgn(a64, TC0_START + TC_COUNT_OFS, TC0_START + TC_COUNT_OFS + 32'd3)
           | in_rgn(a64, TC1_START + TC_COUNT_OFS, TC1_START + TC_COUNT_OFS + 32'd3);

    err_align  = (st_addr[2:0] & amask) != 3'd0;
    err_size   = (st_size_e'(st_size) == SZ_D) && (DATA_W == 32);
    err_range  = ~in_any;
    err_periph = (in_tc && (st_size_e'(st_size) != SZ_W)) || in_cnt;
    exc_ades   = st_valid & (err_align | err_size | err_range | err_periph);
  end

endmodule

// File: rtl/store_queue.sv
// MEM-stage store queue: decodes stores (via store_align), buffers legal ones
// in a DEPTH-entry FIFO and drains the head over a req/ack bus handshake.
//   st_valid/st_size/st_addr/st_wdata, st_ready, exc_ades : MEM-stage side
//   ld_addr, ld_hazard : a pending store covers the load's word
//   mem_req/mem_addr/mem_byteen/mem_wdata, mem_ack : bus side (head entry)
//   empty : no pending stores
// Optional build macro STQ_MERGE_EN: a legal store to the same word as the
// newest (non-draining) entry is merged into it instead of taking a new slot.
module store_queue
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                st_valid,
  input  logic [1:0]          st_size,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_wdata,
  output logic                st_ready,
  output logic                exc_ades,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                ld_hazard,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_byteen,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  output logic                empty
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_MASK = (PW+1)'(DEPTH - 1);

  logic [ADDR_W-1:0] al_addr;
  logic [NB-1:0]     al_byteen;
  logic [DATA_W-1:0] al_wdata;

  store_align #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_align (
    .st_valid  (st_valid),
    .st_size   (st_size),
    .st_addr   (st_addr),
    .st_wdata  (st_wdata),
    .al_addr   (al_addr),
    .al_byteen (al_byteen),
    .al_wdata  (al_wdata),
    .exc_ades  (exc_ades)
  );

  store_entry_t    fifo [DEPTH];
  store_entry_t    new_ent, head_ent;
  logic [PW:0]     head, tail, count;
  logic [PW-1:0]   head_idx, tail_idx;
  logic            full, is_empty, push, pop;

  assign head_idx = head[PW-1:0];
  assign tail_idx = tail[PW-1:0];
  assign full     = (count == (PW+1)'(DEPTH));
  assign is_empty = (count == '0);
  assign pop      = ~is_empty & mem_ack;

  always_comb begin
    new_ent        = '0;
    new_ent.addr   = ENT_ADDR_W'(al_addr);
    new_ent.byteen = ENT_NB'(al_byteen);
    new_ent.wdata  = ENT_DATA_W'(al_wdata);
  end

`ifdef STQ_MERGE_EN
  logic [PW-1:0] last_idx;
  logic          merge;
  store_entry_t  merged;

  // count >= 2 guarantees the newest entry is not the head being offered
  assign last_idx = tail_idx - PW'(1);
  assign merge    = st_valid & ~exc_ades & (count >= (PW+1)'(2))
                  & (fifo[last_idx].addr == new_ent.addr);

  always_comb begin
    merged        = fifo[last_idx];
    merged.byteen = fifo[last_idx].byteen | new_ent.byteen;
    for (int unsigned b = 0; b < ENT_NB; b++)
      if (new_ent.byteen[b]) merged.wdata[8*b +: 8] = new_ent.wdata[8*b +: 8];
  end

  assign st_ready = ~full | merge;
  assign push     = st_valid & ~exc_ades & ~full & ~merge;
`else
  assign st_ready = ~full;
  assign push     = st_valid & ~exc_ades & ~full;
`endif

  // Entry storage is not reset; every reader is qualified by count.
  always_ff @(posedge clk) begin
    if (push) fifo[tail_idx] <= new_ent;
`ifdef STQ_MERGE_EN
    if (merge) fifo[last_idx] <= merged;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= (tail + (PW+1)'(1)) & PTR_MASK;
      if (pop)  head <= (head + (PW+1)'(1)) & PTR_MASK;
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_ent   = fifo[head_idx];
  assign mem_req    = ~is_empty;
  assign empty      = is_empty;
  assign mem_addr   = mem_req ? head_ent.addr[ADDR_W-1:0]   : '0;
  assign mem_byteen = mem_req ? head_ent.byteen[NB-1:0]     : '0;
  assign mem_wdata  = mem_req ? head_ent.wdata[DATA_W-1:0]  : '0;

  logic [PW-1:0] ofs;

  always_comb begin
    ld_hazard = 1'b0;
    ofs       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ofs = PW'(i) - head_idx;  // age of slot i relative to the head
      if (({1'b0, ofs} < count) &&
          ((fifo[i].addr[ADDR_W-1:0] >> LB) == (ld_addr >> LB)))
        ld_hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
  import store_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // 32-bit instance
  logic        st_valid, st_ready, exc_ades, ld_hazard, mem_req, mem_ack, empty;
  logic [1:0]  st_size;
  logic [31:0] st_addr, st_wdata, ld_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;
  // 64-bit instance
  logic        x_st_valid, x_st_ready, x_exc_ades, x_ld_hazard, x_mem_req, x_mem_ack, x_empty;
  logic [1:0]  x_st_size;
  logic [31:0] x_st_addr, x_ld_addr, x_mem_addr;
  logic [63:0] x_st_wdata, x_mem_wdata;
  logic [7:0]  x_mem_byteen;

  store_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_size(st_size),
    .st_addr(st_addr), .st_wdata(st_wdata), .st_ready(st_ready),
    .exc_ades(exc_ades), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .empty(empty)
  );

  store_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .st_valid(x_st_valid), .st_size(x_st_size),
    .st_addr(x_st_addr), .st_wdata(x_st_wdata), .st_ready(x_st_ready),
    .exc_ades(x_exc_ades), .ld_addr(x_ld_addr), .ld_hazard(x_ld_hazard),
    .mem_req(x_mem_req), .mem_addr(x_mem_addr), .mem_byteen(x_mem_byteen),
    .mem_wdata(x_mem_wdata), .mem_ack(x_mem_ack), .empty(x_empty)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       output logic rdy);
    st_valid = 1'b1; st_size = sz; st_addr = a; st_wdata = d;
    #1;
    rdy = st_ready;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain_chk(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
    chk({tag, " req"},   64'(mem_req), 64'd1);
    chk({tag, " addr"},  64'(mem_addr), 64'(a));
    chk({tag, " be"},    64'(mem_byteen), 64'(be));
    chk({tag, " wdata"}, 64'(mem_wdata), 64'(wd));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  typedef struct {
    logic        w64;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        ades;
    logic [31:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic rdy;
    logic exp_rdy [6];
    string s;

    vecs.push_back('{1'b0, SZ_B, 32'h0000_0003, 64'hAB,        1'b0, 32'h0,      8'h8,  64'hAB00_0000});
    vecs.push_back('{1'b0, SZ_H, 32'h0000_0001, 64'h1234,      1'b1, 32'h0,      8'h0,  64'h0});
    vecs.push_back('{1'b0, SZ_W, 32'h0000_7F08, 64'h1,         1'b1, 32'h0,      8'h0,  64'h0});
    vecs.push_back('{1'b0, SZ_W, 32'h0000_7F04, 64'h1234_5678, 1'b0, 32'h7F04,   8'hF,  64'h1234_5678});
    vecs.push_back('{1'b0, SZ_B, 32'h0000_7F04, 64'h5,         1'b1, 32'h0,      8'h0,  64'h0});
    vecs.push_back('{1'b0, SZ_W, 32'h0000_3000, 64'h5,         1'b1, 32'h0,      8'h0,  64'h0});
    vecs.push_back('{1'b0, SZ_H, 32'h0000_2002, 64'hFFFF_BEEF, 1'b0, 32'h2000,   8'hC,  64'hBEEF_0000});
    vecs.push_back('{1'b0, SZ_B, 32'h0000_7F21, 64'h5A,        1'b0, 32'h7F20,   8'h2,  64'h5A00});
    vecs.push_back('{1'b0, SZ_D, 32'h0000_0008, 64'h1,         1'b1, 32'h0,      8'h0,  64'h0});
    vecs.push_back('{1'b0, SZ_W, 32'h0000_2FFC, 64'hCAFE_F00D, 1'b0, 32'h2FFC,   8'hF,  64'hCAFE_F00D});
    vecs.push_back('{1'b0, SZ_W, 32'h0000_7F18, 64'h1,         1'b1, 32'h0,      8'h0,  64'h0});
    vecs.push_back('{1'b0, SZ_H, 32'h0000_7F14, 64'h1,         1'b1, 32'h0,      8'h0,  64'h0});
    vecs.push_back('{1'b0, SZ_W, 32'h0000_7F10, 64'h0BAD_CAFE, 1'b0, 32'h7F10,   8'hF,  64'h0BAD_CAFE});
    vecs.push_back('{1'b0, SZ_B, 32'h0000_2FFF, 64'h01,        1'b0, 32'h2FFC,   8'h8,  64'h0100_0000});
    vecs.push_back('{1'b1, SZ_D, 32'h0000_0008, 64'h1122_3344_5566_7788, 1'b0, 32'h8, 8'hFF, 64'h1122_3344_5566_7788});
    vecs.push_back('{1'b1, SZ_D, 32'h0000_0004, 64'h1,         1'b1, 32'h0,      8'h0,  64'h0});
    vecs.push_back('{1'b1, SZ_W, 32'h0000_0004, 64'hDEAD_BEEF, 1'b0, 32'h0,      8'hF0, 64'hDEAD_BEEF_0000_0000});
    vecs.push_back('{1'b1, SZ_B, 32'h0000_7F23, 64'hFFFF_FFFF_FFFF_FF77, 1'b0, 32'h7F20, 8'h08, 64'h7700_0000});
    vecs.push_back('{1'b1, SZ_H, 32'h0000_0006, 64'h1234,      1'b0, 32'h0,      8'hC0, 64'h1234_0000_0000_0000});

    reset = 1'b1;
    st_valid = 1'b0; st_size = '0; st_addr = '0; st_wdata = '0; ld_addr = '0; mem_ack = 1'b0;
    x_st_valid = 1'b0; x_st_size = '0; x_st_addr = '0; x_st_wdata = '0; x_ld_addr = '0; x_mem_ack = 1'b0;
    tick();
    tick();
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst empty", 64'(empty), 64'd1);
    chk("rst st_ready", 64'(st_ready), 64'd1);
    chk("rst ld_hazard", 64'(ld_hazard), 64'd0);
    chk("rst byteen", 64'(mem_byteen), 64'd0);
    chk("rst wdata", 64'(mem_wdata), 64'd0);
    chk("rst64 byteen", 64'(x_mem_byteen), 64'd0);
    reset = 1'b0;
    tick();

    // Table: one store at a time, drained immediately.
    foreach (vecs[i]) begin
      v = vecs[i];
      st_valid = ~v.w64;  x_st_valid = v.w64;
      st_size = v.size;   x_st_size = v.size;
      st_addr = v.addr;   x_st_addr = v.addr;
      st_wdata = v.wdata[31:0]; x_st_wdata = v.wdata;
      #1;
      s = $sformatf("v%0d", i);
      chk({s, " ades"}, 64'(v.w64 ? x_exc_ades : exc_ades), 64'(v.ades));
      chk({s, " req_pre"}, 64'(v.w64 ? x_mem_req : mem_req), 64'd0);
      tick();
      st_valid = 1'b0; x_st_valid = 1'b0;
      if (v.ades) begin
        chk({s, " no_enq"}, 64'(v.w64 ? x_mem_req : mem_req), 64'd0);
      end else begin
        chk({s, " req"}, 64'(v.w64 ? x_mem_req : mem_req), 64'd1);
        chk({s, " addr"}, 64'(v.w64 ? x_mem_addr : mem_addr), 64'(v.e_addr));
        chk({s, " be"}, v.w64 ? 64'(x_mem_byteen) : 64'(mem_byteen), 64'(v.e_be));
        chk({s, " wdata"}, v.w64 ? x_mem_wdata : 64'(mem_wdata), v.e_wd);
        mem_ack = 1'b1; x_mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; x_mem_ack = 1'b0;
        chk({s, " empty"}, 64'(v.w64 ? x_empty : empty), 64'd1);
      end
    end

    // Fill to full with ack held low, then pop and enqueue together.
    for (int k = 0; k < 4; k++) begin
      st_valid = 1'b1; st_size = SZ_W; st_addr = 32'(32'h10 + 4 * k); st_wdata = 32'(32'hA0 + k);
      #1;
      chk($sformatf("fill%0d ready", k), 64'(st_ready), 64'd1);
      tick();
    end
    st_addr = 32'h20; st_wdata = 32'hA4;
    #1;
    chk("full ready", 64'(st_ready), 64'd0);
    mem_ack = 1'b1;
    #1;
    chk("full ready w/ack", 64'(st_ready), 64'd0);
    chk("full head", 64'(mem_addr), 64'h10);
    tick();
    st_valid = 1'b0; mem_ack = 1'b0;
    #1;
    chk("after pop ready", 64'(st_ready), 64'd1);
    chk("after pop head", 64'(mem_addr), 64'h14);
    st_valid = 1'b1; st_addr = 32'h24; st_wdata = 32'hA5; mem_ack = 1'b1;
    tick();
    st_valid = 1'b0; mem_ack = 1'b0;
    drain_chk("d0", 32'h18, 4'hF, 32'hA2);
    drain_chk("d1", 32'h1C, 4'hF, 32'hA3);
    drain_chk("d2", 32'h24, 4'hF, 32'hA5);
    chk("drained empty", 64'(empty), 64'd1);
    chk("drained req", 64'(mem_req), 64'd0);

    // Load hazard against a pending word store.
    issue(SZ_W, 32'h100, 32'h99, rdy);
    ld_addr = 32'h102; #1;
    chk("haz 102", 64'(ld_hazard), 64'd1);
    ld_addr = 32'h104; #1;
    chk("haz 104", 64'(ld_hazard), 64'd0);
    ld_addr = 32'h100; #1;
    chk("haz 100", 64'(ld_hazard), 64'd1);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    ld_addr = 32'h102; #1;
    chk("haz after ack", 64'(ld_hazard), 64'd0);

    // Ack while empty is ignored.
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("idle ack empty", 64'(empty), 64'd1);
    issue(SZ_W, 32'h50, 32'h5050, rdy);
    drain_chk("idle", 32'h50, 4'hF, 32'h5050);
    chk("idle empty", 64'(empty), 64'd1);

    // Reset mid-drain with ack asserted discards everything.
    issue(SZ_W, 32'h60, 32'h1, rdy);
    issue(SZ_W, 32'h64, 32'h2, rdy);
    mem_ack = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    #1;
    chk("midrst empty", 64'(empty), 64'd1);
    chk("midrst req", 64'(mem_req), 64'd0);
    chk("midrst ready", 64'(st_ready), 64'd1);
    chk("midrst be", 64'(mem_byteen), 64'd0);
    chk("midrst wdata", 64'(mem_wdata), 64'd0);
    issue(SZ_B, 32'h71, 32'h3C, rdy);
    drain_chk("postrst", 32'h70, 4'h2, 32'h3C00);

    // Same-word bytes while the entry is the head being offered: never merged.
    issue(SZ_B, 32'h400, 32'h11, rdy);
    issue(SZ_B, 32'h401, 32'h22, rdy);
    drain_chk("hm0", 32'h400, 4'h1, 32'h11);
    drain_chk("hm1", 32'h400, 4'h2, 32'h2200);
    chk("hm empty", 64'(empty), 64'd1);

    // Same-word bytes behind the head.
`ifdef STQ_MERGE_EN
    for (int k = 0; k < 6; k++) exp_rdy[k] = 1'b1;
`else
    for (int k = 0; k < 6; k++) exp_rdy[k] = (k < 4);
`endif
    issue(SZ_W, 32'h100, 32'h1, rdy);  chk("mg0 ready", 64'(rdy), 64'(exp_rdy[0]));
    issue(SZ_B, 32'h200, 32'h11, rdy); chk("mg1 ready", 64'(rdy), 64'(exp_rdy[1]));
    issue(SZ_B, 32'h201, 32'h22, rdy); chk("mg2 ready", 64'(rdy), 64'(exp_rdy[2]));
    issue(SZ_W, 32'h300, 32'hC3, rdy); chk("mg3 ready", 64'(rdy), 64'(exp_rdy[3]));
    issue(SZ_W, 32'h304, 32'hB4, rdy); chk("mg4 ready", 64'(rdy), 64'(exp_rdy[4]));
    issue(SZ_B, 32'h305, 32'h77, rdy); chk("mg5 ready", 64'(rdy), 64'(exp_rdy[5]));
    drain_chk("mgd0", 32'h100, 4'hF, 32'h1);
`ifdef STQ_MERGE_EN
    drain_chk("mgd1", 32'h200, 4'h3, 32'h2211);
    drain_chk("mgd2", 32'h300, 4'hF, 32'hC3);
    drain_chk("mgd3", 32'h304, 4'hF, 32'h77B4);
`else
    drain_chk("mgd1", 32'h200, 4'h1, 32'h11);
    drain_chk("mgd2", 32'h200, 4'h2, 32'h2200);
    drain_chk("mgd3", 32'h300, 4'hF, 32'hC3);
`endif
    chk("mg empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
